// File: rtl/nios_processor_led_out_pkg.sv
// Shared definitions for the LED output PIO: register word addresses and
// the write-strobe decode used by the top level.
package nios_processor_led_out_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_TOGGLE = 2'd3;

  // A bus write happens only when the slave is selected and the
  // active-low write strobe is asserted.
  function automatic logic is_write(input logic chipselect, input logic write_n);
    return chipselect & ~write_n;
  endfunction

endpackage

// File: rtl/nios_processor_led_out_if.sv
// Avalon-MM slave bus bundle for the LED output PIO (word address,
// active-low write strobe, 32-bit data in both directions).
interface nios_processor_led_out_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/nios_processor_blink_timer.sv
// Prescaled blink phase generator. The phase holds for period+1 cycles and
// then inverts; restart forces a fresh phase 0 with the counter cleared.
module nios_processor_blink_timer #(
  parameter int unsigned PERIOD_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                restart,
  output logic                phase
);

  logic [PERIOD_W-1:0] cnt;

  // Cycle counter with wrap-and-toggle; restart has priority over a wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (restart) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == period) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nios_processor_led_out.sv
// LED bar output PIO with hardware blink. The CPU sets a static pattern and
// a blink mask; masked bits are inverted whenever the blink phase is high.
// Address 3 writes XOR-toggle the pattern and reads return the live LEDs.
module nios_processor_led_out
  import nios_processor_led_out_pkg::*;
#(
  parameter int unsigned          WIDTH        = 8,
  parameter logic [WIDTH-1:0]     RESET_VALUE  = '0,
  parameter int unsigned          PERIOD_W     = 32,
  parameter logic [PERIOD_W-1:0]  PERIOD_RESET = PERIOD_W'(25000000)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  nios_processor_led_out_if.slave  bus,
  output logic [WIDTH-1:0]         out_port
);

  logic [WIDTH-1:0]    data;
  logic [WIDTH-1:0]    mask;
  logic [PERIOD_W-1:0] period;
  logic                phase;
  logic                wr;
  logic                restart;
  logic [31:0]         rd_next;

  // Upper write bits beyond the register widths are deliberately dropped.
  wire unused_wdata = &{1'b0, bus.writedata};

  assign wr      = is_write(bus.chipselect, bus.write_n);
  assign restart = wr && (bus.address == ADDR_PERIOD);

  // LED pattern register: direct load or XOR toggle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= RESET_VALUE;
    end else if (wr && bus.address == ADDR_DATA) begin
      data <= bus.writedata[WIDTH-1:0];
    end else if (wr && bus.address == ADDR_TOGGLE) begin
      data <= data ^ bus.writedata[WIDTH-1:0];
    end
  end

  // Blink mask and blink period registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask   <= '0;
      period <= PERIOD_RESET;
    end else if (wr) begin
      if (bus.address == ADDR_MASK)   mask   <= bus.writedata[WIDTH-1:0];
      if (bus.address == ADDR_PERIOD) period <= bus.writedata[PERIOD_W-1:0];
    end
  end

  nios_processor_blink_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (period),
    .restart (restart),
    .phase   (phase)
  );

  // LED drive: masked bits follow the blink phase.
  always_comb begin
    out_port = data ^ (mask & {WIDTH{phase}});
  end

  // Read mux over pre-edge register values, zero-extended to the bus width.
  always_comb begin
    rd_next = '0;
    case (bus.address)
      ADDR_DATA:   rd_next = 32'(data);
      ADDR_MASK:   rd_next = 32'(mask);
      ADDR_PERIOD: rd_next = 32'(period);
      ADDR_TOGGLE: rd_next = 32'(out_port);
      default:     rd_next = '0;
    endcase
  end

  // Readdata is refreshed every cycle regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_nios_processor_led_out.sv
// Self-checking bench for the LED output PIO with hardware blink.
module tb_nios_processor_led_out;

  logic       clk;
  logic       reset_n;
  logic [7:0] out_port;
  int checks;
  int failures;

  nios_processor_led_out_if bus ();

  nios_processor_led_out #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: registers as the CPU sees them, plus the number of
  // clock edges since the blink timer was last restarted.
  logic [7:0]  m_data;
  logic [7:0]  m_mask;
  logic [31:0] m_period;
  longint      m_k;
  logic [31:0] m_rd;

  function automatic logic [7:0] model_out();
    longint plen;
    logic   ph;
    plen = longint'(m_period) + 1;
    ph   = ((m_k / plen) % 2) == 1;
    return m_data ^ (ph ? m_mask : 8'h00);
  endfunction

  wire m_wr      = bus.chipselect && !bus.write_n;
  wire m_restart = m_wr && (bus.address == 2'd2);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data   <= 8'hA5;
      m_mask   <= 8'h00;
      m_period <= 32'd25000000;
      m_k      <= 0;
      m_rd     <= 32'd0;
    end else begin
      case (bus.address)
        2'd0: m_rd <= {24'd0, m_data};
        2'd1: m_rd <= {24'd0, m_mask};
        2'd2: m_rd <= m_period;
        default: m_rd <= {24'd0, model_out()};
      endcase
      if (m_wr) begin
        case (bus.address)
          2'd0: m_data   <= bus.writedata[7:0];
          2'd1: m_mask   <= bus.writedata[7:0];
          2'd2: m_period <= bus.writedata;
          default: m_data <= m_data ^ bus.writedata[7:0];
        endcase
      end
      m_k <= m_restart ? 0 : m_k + 1;
    end
  end

  task automatic bus_idle(input logic [1:0] addr);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = addr;
    bus.writedata  = 32'd0;
  endtask

  // Called at a falling edge; returns at the falling edge after the write.
  task automatic bus_write(input logic [1:0] addr, input logic [31:0] val);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = addr;
    bus.writedata  = val;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    bus_idle(2'd0);
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_port !== 8'hA5) begin
      failures++;
      $display("FAIL reset_out_port got=%h want=a5", out_port);
    end
    // Blink fast, then reset in the middle of a cycle.
    bus_write(2'd1, 32'hFF);
    bus_write(2'd2, 32'd1);
    bus_write(2'd0, 32'h00);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (out_port !== 8'hA5) begin
      failures++;
      $display("FAIL async_reset_out_port got=%h want=a5", out_port);
    end
    checks++;
    if (bus.readdata !== 32'd0) begin
      failures++;
      $display("FAIL async_reset_readdata got=%h want=0", bus.readdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bus_idle(2'd2);
    @(negedge clk);
    checks++;
    if (bus.readdata !== 32'd25000000) begin
      failures++;
      $display("FAIL reset_period_read got=%0d want=25000000", bus.readdata);
    end
    checks++;
    if (out_port !== 8'hA5) begin
      failures++;
      $display("FAIL reset_no_blink got=%h want=a5", out_port);
    end
  endtask

  task automatic test_static();
    bus.address = 2'd0;
    @(negedge clk);
    bus_write(2'd0, 32'hFFFF_FF3C);
    checks++;
    if (out_port !== 8'h3C) begin
      failures++;
      $display("FAIL static_out_port got=%h want=3c", out_port);
    end
    checks++;
    if (bus.readdata !== 32'h0000_00A5) begin
      failures++;
      $display("FAIL read_during_write got=%h want=000000a5", bus.readdata);
    end
    @(negedge clk);
    checks++;
    if (bus.readdata !== 32'h0000_003C) begin
      failures++;
      $display("FAIL static_readback got=%h want=0000003c", bus.readdata);
    end
  endtask

  task automatic test_blink();
    logic [7:0] exp;
    bus_write(2'd0, 32'h00);
    bus_write(2'd1, 32'h0F);
    bus_write(2'd2, 32'd3);
    for (int i = 0; i < 12; i++) begin
      exp = ((i / 4) % 2 == 1) ? 8'h0F : 8'h00;
      checks++;
      if (out_port !== exp) begin
        failures++;
        $display("FAIL blink_cycle%0d got=%h want=%h", i, out_port, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_toggle_wrap();
    bus_write(2'd0, 32'h3C);
    bus_write(2'd1, 32'h01);
    bus_write(2'd2, 32'd3);
    repeat (3) @(negedge clk);
    checks++;
    if (out_port !== 8'h3C) begin
      failures++;
      $display("FAIL pre_wrap_out got=%h want=3c", out_port);
    end
    bus_write(2'd3, 32'hFF);
    checks++;
    if (out_port !== 8'hC2) begin
      failures++;
      $display("FAIL toggle_wrap_out got=%h want=c2", out_port);
    end
    checks++;
    if (bus.readdata !== 32'h0000_003C) begin
      failures++;
      $display("FAIL toggle_read_old got=%h want=0000003c", bus.readdata);
    end
    bus.address = 2'd0;
    @(negedge clk);
    checks++;
    if (bus.readdata !== 32'h0000_00C3) begin
      failures++;
      $display("FAIL toggle_data got=%h want=000000c3", bus.readdata);
    end
  endtask

  task automatic test_period_edge();
    logic [7:0] exp;
    bus_write(2'd0, 32'h00);
    bus_write(2'd1, 32'h80);
    bus_write(2'd2, 32'd0);
    for (int i = 0; i < 8; i++) begin
      exp = (i % 2 == 1) ? 8'h80 : 8'h00;
      checks++;
      if (out_port !== exp) begin
        failures++;
        $display("FAIL period0_cycle%0d got=%h want=%h", i, out_port, exp);
      end
      @(negedge clk);
    end
    bus_write(2'd2, 32'd5);
    repeat (7) @(negedge clk);
    checks++;
    if (out_port !== 8'h80) begin
      failures++;
      $display("FAIL period5_phase1 got=%h want=80", out_port);
    end
    bus_write(2'd2, 32'd5);
    for (int i = 0; i < 8; i++) begin
      exp = ((i / 6) % 2 == 1) ? 8'h80 : 8'h00;
      checks++;
      if (out_port !== exp) begin
        failures++;
        $display("FAIL period_rewrite_cycle%0d got=%h want=%h", i, out_port, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignored();
    logic [7:0] exp_live;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b0;
    bus.address    = 2'd0;
    bus.writedata  = $urandom | 32'h1;
    @(negedge clk);
    bus_idle(2'd0);
    @(negedge clk);
    checks++;
    if (bus.readdata !== 32'd0) begin
      failures++;
      $display("FAIL ignored_write_data got=%h want=0", bus.readdata);
    end
    bus.address = 2'd3;
    exp_live = model_out();
    @(negedge clk);
    checks++;
    if (bus.readdata !== {24'd0, exp_live}) begin
      failures++;
      $display("FAIL live_out_read got=%h want=%h", bus.readdata, {24'd0, exp_live});
    end
  endtask

  task automatic test_random();
    int op;
    bus_idle(2'd0);
    @(negedge clk);
    for (int i = 0; i < 400; i++) begin
      checks++;
      if (out_port !== model_out()) begin
        failures++;
        $display("FAIL rand_out_port it=%0d got=%h want=%h", i, out_port, model_out());
      end
      checks++;
      if (bus.readdata !== m_rd) begin
        failures++;
        $display("FAIL rand_readdata it=%0d got=%h want=%h", i, bus.readdata, m_rd);
      end
      op = $urandom_range(0, 3);
      bus.address   = 2'($urandom_range(0, 3));
      bus.writedata = $urandom;
      if (bus.address == 2'd2) bus.writedata = $urandom_range(0, 6);
      bus.chipselect = (op != 0);
      bus.write_n    = !(op == 1 || op == 2);
      if (op == 3) bus.chipselect = 1'b0;
      if (op == 2) bus.chipselect = 1'b0;
      if (op == 1) bus.chipselect = 1'b1;
      @(negedge clk);
    end
    bus_idle(2'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_static();
    test_blink();
    test_toggle_wrap();
    test_period_edge();
    test_ignored();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
